// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared encodings and default widths for the RSA exponentiation datapath
// Contents:
//    BIT_LEN_DEF, COUNT_WIDTH_DEF, EXP_LEN_DEF : default widths shared with mon_prod
//    state_t : operation sequence of mod_exp_ctrl
//    phase_t : per-operation handshake phase with mon_prod
package rsa_pkg;

   localparam int BIT_LEN_DEF     = 64;
   localparam int COUNT_WIDTH_DEF = 5;
   localparam int EXP_LEN_DEF     = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TO_X,
      ST_TO_ONE,
      ST_SQR,
      ST_MUL,
      ST_FROM,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_WAIT,
      PH_GAP
   } phase_t;

endpackage

// File: rtl/mod_cond_sub.sv
// rtl/mod_cond_sub.sv - conditional subtraction bringing a Montgomery product into [0, M)
// Ports:
//    p   in  BIT_LEN+1  raw product, known to be < 2M
//    m   in  BIT_LEN    modulus
//    red out BIT_LEN    p >= M ? p - M : p
module mod_cond_sub #(
   parameter int BIT_LEN = 64
) (
   input  logic [BIT_LEN:0]   p,
   input  logic [BIT_LEN-1:0] m,
   output logic [BIT_LEN-1:0] red
);

   logic [BIT_LEN:0] m_ext;
   logic [BIT_LEN:0] diff;

   always_comb begin
      m_ext = {1'b0, m};
      diff  = p - m_ext;
      // Since p < 2M, the difference always fits in BIT_LEN bits.
      red   = (p >= m_ext) ? diff[BIT_LEN-1:0] : p[BIT_LEN-1:0];
   end

endmodule

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external mon_prod
// Ports:
//    clk, rst_n                   clock, async active-low reset
//    start                        begin an exponentiation (accepted only in IDLE)
//    base, exponent, modulus      X, E, M (latched on accepted start)
//    r2_mod, num_words            R^2 mod M and word count (latched on accepted start)
//    busy, done, result           status and X^E mod M
//    mp_start, mp_a, mp_b         mon_prod request and operands
//    mp_m, mp_words               latched modulus and word count for mon_prod
//    mp_stop, mp_p                mon_prod completion level and product (< 2M)
module mod_exp_ctrl
   import rsa_pkg::*;
#(
   parameter int BIT_LEN     = BIT_LEN_DEF,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
   parameter int EXP_LEN     = EXP_LEN_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BIT_LEN-1:0]     base,
   input  logic [EXP_LEN-1:0]     exponent,
   input  logic [BIT_LEN-1:0]     modulus,
   input  logic [BIT_LEN-1:0]     r2_mod,
   input  logic [COUNT_WIDTH-1:0] num_words,
   output logic                   busy,
   output logic                   done,
   output logic [BIT_LEN-1:0]     result,
   output logic                   mp_start,
   output logic [BIT_LEN-1:0]     mp_a,
   output logic [BIT_LEN-1:0]     mp_b,
   output logic [BIT_LEN-1:0]     mp_m,
   output logic [COUNT_WIDTH-1:0] mp_words,
   input  logic                   mp_stop,
   input  logic [BIT_LEN:0]       mp_p
);

   localparam int IDX_W = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;

   state_t state_q, state_d;
   phase_t phase_q, phase_d;

   logic [IDX_W-1:0]   idx_q;
   logic [BIT_LEN-1:0] x_q, r2_q, xb_q, ab_q, res_q;
   logic [EXP_LEN-1:0] e_q;
   logic [BIT_LEN-1:0] op_a, op_b;
   logic [BIT_LEN-1:0] red;

   logic accept, issue, capture, idx_dec, finish;

   mod_cond_sub #(
      .BIT_LEN (BIT_LEN)
   ) u_cond_sub (
      .p   (mp_p),
      .m   (mp_m),
      .red (red)
   );

   assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done = (state_q == ST_DONE);

   // Operand selection for the product belonging to the current state.
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (state_q)
         ST_TO_X:   begin op_a = x_q;                op_b = r2_q;             end
         ST_TO_ONE: begin op_a = BIT_LEN'(1);        op_b = r2_q;             end
         ST_SQR:    begin op_a = ab_q;               op_b = ab_q;             end
         ST_MUL:    begin op_a = ab_q;               op_b = xb_q;             end
         ST_FROM:   begin op_a = ab_q;               op_b = BIT_LEN'(1);      end
         default:   begin op_a = '0;                 op_b = '0;               end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= PH_ISSUE;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      accept  = 1'b0;
      issue   = 1'b0;
      capture = 1'b0;
      idx_dec = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_TO_X;
               phase_d = PH_ISSUE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            case (phase_q)
               // mon_prod has no reset, so a stale stop must clear before a new request.
               PH_ISSUE: begin
                  if (!mp_stop) begin
                     issue   = 1'b1;
                     phase_d = PH_WAIT;
                  end
               end
               PH_WAIT: begin
                  if (mp_stop) begin
                     capture = 1'b1;
                     phase_d = PH_GAP;
                  end
               end
               default: begin
                  phase_d = PH_ISSUE;
                  case (state_q)
                     ST_TO_X:   state_d = ST_TO_ONE;
                     ST_TO_ONE: state_d = ST_SQR;
                     ST_SQR: begin
                        if (e_q[idx_q]) begin
                           state_d = ST_MUL;
                        end else if (idx_q == '0) begin
                           state_d = ST_FROM;
                        end else begin
                           idx_dec = 1'b1;
                           state_d = ST_SQR;
                        end
                     end
                     ST_MUL: begin
                        if (idx_q == '0) begin
                           state_d = ST_FROM;
                        end else begin
                           idx_dec = 1'b1;
                           state_d = ST_SQR;
                        end
                     end
                     default: begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                     end
                  endcase
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         e_q      <= '0;
         r2_q     <= '0;
         xb_q     <= '0;
         ab_q     <= '0;
         res_q    <= '0;
         idx_q    <= '0;
         result   <= '0;
         mp_start <= 1'b0;
         mp_a     <= '0;
         mp_b     <= '0;
         mp_m     <= '0;
         mp_words <= '0;
      end else begin
         if (accept) begin
            x_q      <= base;
            e_q      <= exponent;
            r2_q     <= r2_mod;
            mp_m     <= modulus;
            mp_words <= num_words;
            idx_q    <= IDX_W'(EXP_LEN - 1);
         end
         // Operands and start are registered on the same edge, so they are
         // already stable when mon_prod first sees the request.
         if (issue) begin
            mp_a     <= op_a;
            mp_b     <= op_b;
            mp_start <= 1'b1;
         end
         if (capture) begin
            mp_start <= 1'b0;
            case (state_q)
               ST_TO_X: xb_q  <= red;
               ST_FROM: res_q <= red;
               default: ab_q  <= red;
            endcase
         end
         if (idx_dec) begin
            idx_q <= idx_q - 1'b1;
         end
         if (finish) begin
            result <= res_q;
         end
      end
   end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - directed bench for mod_exp_ctrl with a behavioural mon_prod
module tb_mod_exp_ctrl;

   localparam int BL   = 64;
   localparam int CW   = 5;
   localparam int EL   = 64;
   localparam int LAT  = 3;
   localparam int HOLD = 4;
   localparam logic [63:0] MOD = 64'd311;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [BL-1:0] base = '0;
   logic [EL-1:0] exponent = '0;
   logic [BL-1:0] modulus = '0;
   logic [BL-1:0] r2_mod = '0;
   logic [CW-1:0] num_words = '0;
   logic          busy, done;
   logic [BL-1:0] result;
   logic          mp_start;
   logic [BL-1:0] mp_a, mp_b, mp_m;
   logic [CW-1:0] mp_words;
   logic          mp_stop = 1'b0;
   logic [BL:0]   mp_p = '0;

   logic [63:0] r2;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mod_exp_ctrl #(.BIT_LEN(BL), .COUNT_WIDTH(CW), .EXP_LEN(EL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
      .modulus(modulus), .r2_mod(r2_mod), .num_words(num_words), .busy(busy),
      .done(done), .result(result), .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b),
      .mp_m(mp_m), .mp_words(mp_words), .mp_stop(mp_stop), .mp_p(mp_p)
   );

   function automatic logic [BL:0] mont(input logic [BL-1:0] a, input logic [BL-1:0] b,
                                        input logic [BL-1:0] m);
      logic [BL+1:0] s;
      s = '0;
      for (int i = 0; i < BL; i++) begin
         if (a[i]) s = s + {2'b00, b};
         if (s[0]) s = s + {2'b00, m};
         s = s >> 1;
      end
      return s[BL:0];
   endfunction

   // Behavioural mon_prod: no reset, fixed latency, stop held HOLD cycles after start drops.
   bit m_busy = 1'b0;
   int m_cnt = 0;
   int m_hold = 0;
   always @(posedge clk) begin
      if (m_busy) begin
         if (!mp_start) m_busy <= 1'b0;
         else if (m_cnt == 1) begin
            mp_stop <= 1'b1;
            m_hold  <= HOLD;
            m_busy  <= 1'b0;
         end else m_cnt <= m_cnt - 1;
      end else if (mp_stop) begin
         if (!mp_start) begin
            if (m_hold == 1) mp_stop <= 1'b0;
            else m_hold <= m_hold - 1;
         end
      end else if (mp_start) begin
         m_busy <= 1'b1;
         m_cnt  <= LAT;
         mp_p   <= mont(mp_a, mp_b, mp_m);
      end
   end

   int   op_cnt = 0;
   int   done_cnt = 0;
   int   bad_issue = 0;
   logic prev_start = 1'b0;
   logic stop_at_edge = 1'b0;
   always @(posedge clk) stop_at_edge <= mp_stop;
   always @(negedge clk) begin
      if (mp_start && !prev_start) begin
         op_cnt = op_cnt + 1;
         if (stop_at_edge) bad_issue = bad_issue + 1;
      end
      prev_start = mp_start;
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic wait_done(output bit to, output logic [63:0] res, output logic busy_at);
      to = 1'b1;
      res = '0;
      busy_at = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done) begin
            to = 1'b0;
            res = result;
            busy_at = busy;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic launch(input logic [63:0] b, input logic [63:0] e);
      base = b;
      exponent = e;
      modulus = MOD;
      r2_mod = r2;
      num_words = 5'd2;
      op_cnt = 0;
      done_cnt = 0;
      bad_issue = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input logic [63:0] b, input logic [63:0] e,
                         output bit to, output logic [63:0] res, output logic busy_at);
      @(negedge clk);
      launch(b, e);
      wait_done(to, res, busy_at);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({busy, done, mp_start} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b expected 000", {busy, done, mp_start});
      end
      compared++;
      if (result !== '0) begin
         mismatched++;
         $display("FAIL reset_result: got %0d expected 0", result);
      end
      compared++;
      if ({mp_a, mp_b} !== '0) begin
         mismatched++;
         $display("FAIL reset_ab: got %h expected 0", {mp_a, mp_b});
      end
      compared++;
      if ({mp_m, mp_words} !== '0) begin
         mismatched++;
         $display("FAIL reset_m_words: got %h expected 0", {mp_m, mp_words});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_exp_one;
      bit to; logic [63:0] res; logic b_at;
      run_op(64'd216, 64'd1, to, res, b_at);
      compared++;
      if (to !== 1'b0) begin mismatched++; $display("FAIL e1_timeout: got 1 expected 0"); end
      compared++;
      if (res !== 64'd216) begin mismatched++; $display("FAIL e1_result: got %0d expected 216", res); end
      compared++;
      if (done_cnt !== 1) begin mismatched++; $display("FAIL e1_done_pulses: got %0d expected 1", done_cnt); end
      compared++;
      if (b_at !== 1'b0) begin mismatched++; $display("FAIL e1_busy_at_done: got %b expected 0", b_at); end
      compared++;
      if (op_cnt !== EL + 4) begin mismatched++; $display("FAIL e1_ops: got %0d expected %0d", op_cnt, EL + 4); end
   endtask

   task automatic test_exp_zero;
      bit to; logic [63:0] res; logic b_at;
      run_op(64'd216, 64'd0, to, res, b_at);
      compared++;
      if (to !== 1'b0 || res !== 64'd1) begin
         mismatched++;
         $display("FAIL e0_result: got %0d (timeout %b) expected 1", res, to);
      end
      compared++;
      if (op_cnt !== EL + 3) begin mismatched++; $display("FAIL e0_ops: got %0d expected %0d", op_cnt, EL + 3); end
      compared++;
      if (mp_words !== 5'd2 || mp_m !== MOD) begin
         mismatched++;
         $display("FAIL e0_latched: got m=%0d words=%0d expected m=311 words=2", mp_m, mp_words);
      end
   endtask

   task automatic test_square;
      bit to; logic [63:0] res; logic b_at;
      run_op(64'd20, 64'd2, to, res, b_at);
      compared++;
      if (to !== 1'b0 || res !== 64'd89) begin
         mismatched++;
         $display("FAIL sq_result: got %0d (timeout %b) expected 89", res, to);
      end
      compared++;
      if (result !== 64'd89) begin mismatched++; $display("FAIL sq_hold: got %0d expected 89", result); end
   endtask

   task automatic test_odd_power;
      bit to; logic [63:0] res; logic b_at;
      run_op(64'd310, 64'd123, to, res, b_at);
      compared++;
      if (to !== 1'b0 || res !== 64'd310) begin
         mismatched++;
         $display("FAIL odd_result: got %0d (timeout %b) expected 310", res, to);
      end
      compared++;
      if (op_cnt !== EL + 6 + 3) begin mismatched++; $display("FAIL odd_ops: got %0d expected %0d", op_cnt, EL + 9); end
   endtask

   task automatic test_fermat_restart;
      bit to; logic [63:0] res; logic b_at;
      @(negedge clk);
      launch(64'd216, 64'd310);
      repeat (150) @(negedge clk);
      start = 1'b1;
      base = 64'd5;
      exponent = 64'd7;
      modulus = 64'd97;
      r2_mod = 64'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(to, res, b_at);
      compared++;
      if (to !== 1'b0 || res !== 64'd1) begin
         mismatched++;
         $display("FAIL fermat_result: got %0d (timeout %b) expected 1", res, to);
      end
      compared++;
      if (op_cnt !== EL + 5 + 3) begin mismatched++; $display("FAIL fermat_ops: got %0d expected %0d", op_cnt, EL + 8); end
      compared++;
      if (done_cnt !== 1) begin mismatched++; $display("FAIL fermat_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_reset_mid_op;
      bit to; logic [63:0] res; logic b_at; bit reached;
      @(negedge clk);
      launch(64'd216, 64'd310);
      reached = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (op_cnt == 10 && mp_stop) begin reached = 1'b1; break; end
      end
      compared++;
      if (reached !== 1'b1) begin mismatched++; $display("FAIL rst_reach_wait10: got 0 expected 1"); end
      rst_n = 1'b0;
      @(negedge clk);
      compared++;
      if ({busy, done, mp_start} !== 3'b000 || result !== '0) begin
         mismatched++;
         $display("FAIL rst_mid_ctrl: got ctrl=%b result=%0d expected 000/0", {busy, done, mp_start}, result);
      end
      compared++;
      if ({mp_a, mp_b, mp_m, mp_words} !== '0) begin
         mismatched++;
         $display("FAIL rst_mid_mp: got %h expected 0", {mp_a, mp_b, mp_m, mp_words});
      end
      rst_n = 1'b1;
      launch(64'd20, 64'd2);
      wait_done(to, res, b_at);
      compared++;
      if (to !== 1'b0 || res !== 64'd89) begin
         mismatched++;
         $display("FAIL rst_rerun_result: got %0d (timeout %b) expected 89", res, to);
      end
      compared++;
      if (bad_issue !== 0) begin mismatched++; $display("FAIL rst_issue_while_stop: got %0d expected 0", bad_issue); end
      compared++;
      if (op_cnt !== EL + 4) begin mismatched++; $display("FAIL rst_rerun_ops: got %0d expected %0d", op_cnt, EL + 4); end
   endtask

   initial begin
      r2 = 64'd1;
      repeat (2 * BL) r2 = (r2 * 64'd2) % MOD;
      test_reset();
      test_exp_one();
      test_exp_zero();
      test_square();
      test_odd_power();
      test_fermat_restart();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
